// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one memory port between fetch and data requesters
// One transaction outstanding at a time; data has priority unless fetch has lost STARVE_MAX times in a row.
module mem_port_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 3
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    output logic                if_ack,
    output logic [DATA_W-1:0]   if_rdata,
    input  logic                dm_req,
    input  logic                dm_we,
    input  logic [ADDR_W-1:0]   dm_addr,
    input  logic [DATA_W-1:0]   dm_wdata,
    input  logic [DATA_W/8-1:0] dm_wstrb,
    output logic                dm_ack,
    output logic [DATA_W-1:0]   dm_rdata,
    output logic                mem_valid,
    input  logic                mem_ready,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_wstrb,
    input  logic                mem_rvalid,
    input  logic [DATA_W-1:0]   mem_rdata,
    output logic                stall_f,
    output logic                stall_m
);

    localparam int CW = $clog2(STARVE_MAX + 1);
    localparam logic [CW-1:0] SMAX = CW'(STARVE_MAX);

    typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

    state_t        state;
    logic          owner;
    logic [CW-1:0] starve_cnt;
    logic          both;
    logic          grant_d;
    logic          resp_done;

    assign both    = if_req & dm_req;
    assign grant_d = dm_req & ~(both & (starve_cnt == SMAX));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            owner      <= 1'b0;
            starve_cnt <= '0;
            mem_valid  <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_wstrb  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (if_req | dm_req) begin
                        state     <= REQ;
                        mem_valid <= 1'b1;
                        owner     <= grant_d;
                        if (grant_d) begin
                            mem_we    <= dm_we;
                            mem_addr  <= dm_addr;
                            mem_wdata <= dm_wdata;
                            mem_wstrb <= dm_we ? dm_wstrb : '0;
                            // a data win under contention implies the counter is below SMAX
                            if (both) begin
                                starve_cnt <= starve_cnt + 1'b1;
                            end
                        end else begin
                            mem_we     <= 1'b0;
                            mem_addr   <= if_addr;
                            mem_wdata  <= '0;
                            mem_wstrb  <= '0;
                            starve_cnt <= '0;
                        end
                    end
                end
                REQ: begin
                    if (mem_ready) begin
                        mem_valid <= 1'b0;
                        state     <= RESP;
                    end
                end
                RESP: begin
                    if (mem_rvalid) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign resp_done = (state == RESP) & mem_rvalid;
    assign if_ack    = resp_done & ~owner;
    assign dm_ack    = resp_done & owner;
    assign if_rdata  = mem_rdata;
    assign dm_rdata  = mem_rdata;
    assign stall_f   = if_req & ~if_ack;
    assign stall_m   = dm_req & ~dm_ack;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed scoreboard bench for mem_port_arbiter
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_ack;
    logic [31:0] if_rdata;
    logic        dm_req;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic [3:0]  dm_wstrb;
    logic        dm_ack;
    logic [31:0] dm_rdata;
    logic        mem_valid;
    logic        mem_ready;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        stall_f;
    logic        stall_m;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic        owner;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } exp_t;

    exp_t sb[$];

    mem_port_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_wstrb(dm_wstrb), .dm_ack(dm_ack), .dm_rdata(dm_rdata),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .stall_f(stall_f), .stall_m(stall_m)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic owner, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] wstrb);
        exp_t e;
        e.owner = owner; e.we = we; e.addr = addr; e.wdata = wdata; e.wstrb = wstrb;
        sb.push_back(e);
    endtask

    // Plays the memory side of one transaction and checks it against the scoreboard head.
    task automatic serve(input int delay, input logic [31:0] rdata, output int waits);
        exp_t e;
        logic is_f;
        int   n;
        @(negedge clk);
        n = 0;
        while (mem_valid !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        waits = n;
        chk("valid_seen", 32'(mem_valid), 32'd1);
        if (sb.size() == 0) begin
            checks++;
            failures++;
            $error("FAIL sb_empty observed=empty expected=entry");
            return;
        end
        e = sb.pop_front();
        is_f = !e.owner;
        chk("mem_we", 32'(mem_we), 32'(e.we));
        chk("mem_addr", mem_addr, e.addr);
        chk("mem_wstrb", 32'(mem_wstrb), 32'(e.wstrb));
        if (e.we) chk("mem_wdata", mem_wdata, e.wdata);
        repeat (delay) begin
            mem_ready = 1'b0;
            @(negedge clk);
            chk("hold_valid", 32'(mem_valid), 32'd1);
            chk("hold_addr", mem_addr, e.addr);
            chk("hold_we", 32'(mem_we), 32'(e.we));
            if (e.we) chk("hold_wdata", mem_wdata, e.wdata);
        end
        mem_ready = 1'b1;
        @(negedge clk);
        mem_ready = 1'b0;
        chk("resp_valid_low", 32'(mem_valid), 32'd0);
        chk("pre_ack", 32'({if_ack, dm_ack}), 32'd0);
        mem_rdata  = rdata;
        mem_rvalid = 1'b1;
        #1;
        chk("if_ack", 32'(if_ack), 32'(is_f));
        chk("dm_ack", 32'(dm_ack), 32'(e.owner));
        if (e.owner) begin
            chk("dm_rdata", dm_rdata, rdata);
            chk("stall_m_ack", 32'(stall_m), 32'd0);
        end else begin
            chk("if_rdata", if_rdata, rdata);
            chk("stall_f_ack", 32'(stall_f), 32'd0);
        end
        @(negedge clk);
        mem_rvalid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        rst_n = 1'b0; if_req = 1'b0; if_addr = '0; dm_req = 1'b0; dm_we = 1'b0;
        dm_addr = '0; dm_wdata = '0; dm_wstrb = '0; mem_ready = 1'b0;
        mem_rvalid = 1'b0; mem_rdata = '0;
        #1;
        chk("rst_valid", 32'(mem_valid), 32'd0);
        chk("rst_we", 32'(mem_we), 32'd0);
        chk("rst_addr", mem_addr, 32'd0);
        chk("rst_wdata", mem_wdata, 32'd0);
        chk("rst_wstrb", 32'(mem_wstrb), 32'd0);
        chk("rst_acks", 32'({if_ack, dm_ack}), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // single fetch, minimum latency
        if_req = 1'b1; if_addr = 32'h100;
        push(1'b0, 1'b0, 32'h100, 32'h0, 4'h0);
        #1 chk("stall_f_wait", 32'(stall_f), 32'd1);
        serve(0, 32'hDEADBEEF, w);
        chk("fetch_latency", w, 32'd0);
        if_req = 1'b0;
        #1 chk("stall_f_after", 32'(stall_f), 32'd0);
        @(negedge clk);

        // store with three cycles of backpressure
        dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h2000; dm_wdata = 32'h12345678; dm_wstrb = 4'hF;
        push(1'b1, 1'b1, 32'h2000, 32'h12345678, 4'hF);
        serve(3, 32'h0, w);
        dm_req = 1'b0;
        @(negedge clk);

        // load: strobes masked to zero
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h2040; dm_wstrb = 4'hF;
        push(1'b1, 1'b0, 32'h2040, 32'h0, 4'h0);
        serve(1, 32'hA5A55A5A, w);
        dm_req = 1'b0;
        @(negedge clk);

        // contention: D,D,D,F,D,D,D,F
        if_req = 1'b1; if_addr = 32'h300;
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h400; dm_wstrb = 4'h3;
        for (int k = 0; k < 8; k++) begin
            if (k % 4 == 3) push(1'b0, 1'b0, 32'h300, 32'h0, 4'h0);
            else            push(1'b1, 1'b0, 32'h400, 32'h0, 4'h0);
        end
        for (int k = 0; k < 8; k++) begin
            serve(0, 32'hC000_0000 + 32'(k), w);
            chk("cont_latency", w, 32'd0);
        end
        if_req = 1'b0; dm_req = 1'b0;
        @(negedge clk);

        // request dropped before any clock edge sees it
        dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h500;
        #2 dm_req = 1'b0;
        repeat (2) begin
            @(negedge clk);
            chk("dropped_req", 32'(mem_valid), 32'd0);
        end

        // reset in RESP, then a stray rvalid
        if_req = 1'b1; if_addr = 32'h600;
        @(negedge clk);
        chk("rst_pre_valid", 32'(mem_valid), 32'd1);
        mem_ready = 1'b1;
        @(negedge clk);
        mem_ready = 1'b0;
        chk("rst_pre_resp", 32'(mem_valid), 32'd0);
        #1 rst_n = 1'b0;
        #1;
        chk("rst_mid_valid", 32'(mem_valid), 32'd0);
        chk("rst_mid_addr", mem_addr, 32'd0);
        if_req = 1'b0;
        mem_rvalid = 1'b1;
        #1;
        chk("rst_mid_ack", 32'({if_ack, dm_ack}), 32'd0);
        rst_n = 1'b1;
        repeat (2) begin
            @(negedge clk);
            chk("stray_ack", 32'({if_ack, dm_ack}), 32'd0);
            chk("stray_valid", 32'(mem_valid), 32'd0);
        end
        mem_rvalid = 1'b0;
        chk("sb_drained", sb.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter ADDR_W, default 32, width of all address buses.
REQ-002 Parameter DATA_W, default 32, width of all data buses; byte-strobe width is DATA_W/8.
REQ-003 Parameter STARVE_MAX, default 3, number of consecutive fetch losses before fetch is forced to win.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 if_req  in  1  fetch-stage read request, held until if_ack.
REQ-007 if_addr  in  ADDR_W  fetch address.
REQ-008 if_ack  out  1  fetch completion pulse.
REQ-009 if_rdata  out  DATA_W  fetch read data, valid only while if_ack=1.
REQ-010 dm_req  in  1  memory-stage load/store request, held until dm_ack.
REQ-011 dm_we  in  1  1=store, 0=load.
REQ-012 dm_addr  in  ADDR_W  data address.
REQ-013 dm_wdata  in  DATA_W  store data.
REQ-014 dm_wstrb  in  DATA_W/8  store byte enables.
REQ-015 dm_ack  out  1  data completion pulse.
REQ-016 dm_rdata  out  DATA_W  load data, valid only while dm_ack=1.
REQ-017 mem_valid  out  1  request to the shared memory port.
REQ-018 mem_ready  in  1  memory accepts request when mem_valid & mem_ready.
REQ-019 mem_we, mem_addr, mem_wdata, mem_wstrb  out  1/ADDR_W/DATA_W/DATA_W/8  registered request fields.
REQ-020 mem_rvalid  in  1  response strobe for both loads and stores (stores: write done).
REQ-021 mem_rdata  in  DATA_W  response data.
REQ-022 stall_f, stall_m  out  1  pipeline stall for fetch / memory stage.

Function
REQ-023 FSM states: IDLE, REQ, RESP; exactly one transaction outstanding at any time.
REQ-024 IDLE: if any request pending, grant one, latch its fields into mem_* registers and the owner bit, go to REQ next cycle; else stay.
REQ-025 Arbitration: data wins over fetch when both pending, except when starve_cnt==STARVE_MAX, then fetch wins.
REQ-026 starve_cnt: +1 (saturating at STARVE_MAX) when both pending and data granted; cleared to 0 whenever fetch granted; unchanged otherwise.
REQ-027 REQ: mem_valid=1 with stable fields; on mem_ready=1 go to RESP; else hold.
REQ-028 RESP: mem_valid=0; on mem_rvalid=1 assert owner's ack combinationally in that cycle, go to IDLE.
REQ-029 if_rdata and dm_rdata are combinational copies of mem_rdata; value is don't-care when the corresponding ack is 0.
REQ-030 Fetch grants drive mem_we=0, mem_wstrb=0; data loads drive mem_wstrb=0 regardless of dm_wstrb.
REQ-031 mem_rvalid outside RESP is ignored; mem_ready outside REQ is ignored.
REQ-032 Minimum latency: req seen in IDLE at cycle N -> mem_valid at N+1 -> ack earliest at N+2 (ready at N+1, rvalid at N+2).
REQ-033 After an ack the FSM spends one cycle in IDLE before the next grant; a request still high in that IDLE cycle is a new request.
REQ-034 stall_f = if_req & ~if_ack; stall_m = dm_req & ~dm_ack (combinational).
REQ-035 Requests are sampled only in IDLE; a request dropped before grant is lost without any memory activity.

Reset
REQ-036 rst_n=0 forces IDLE, starve_cnt=0, owner=fetch, and clears mem_valid, mem_we, mem_addr, mem_wdata, mem_wstrb immediately, without waiting for clk.
REQ-037 With rst_n=0, if_ack=dm_ack=0; any in-flight transaction is abandoned, and a late mem_rvalid after reset release is ignored per REQ-031.

Verification
REQ-038 Single fetch: if_req=1, addr=0x100, ready=1 at first REQ cycle, rvalid=1 with rdata=0xDEADBEEF the next cycle -> if_ack pulse at cycle N+2, if_rdata=0xDEADBEEF, stall_f=0 thereafter.
REQ-039 Store with backpressure: dm_we=1, addr=0x2000, wdata=0x12345678, wstrb=0xF, mem_ready low 3 cycles -> mem_valid and fields stable for 4 cycles, mem_we=1, dm_ack on rvalid, if_ack stays 0.
REQ-040 Contention/starvation: if_req and dm_req held high continuously with immediate ready/rvalid -> grant order D,D,D,F,D,D,D,F (STARVE_MAX=3).
REQ-041 Load wstrb masking: dm_we=0, dm_wstrb=0xF -> mem_wstrb=0, mem_we=0; dm_rdata equals mem_rdata when dm_ack=1.
REQ-042 Reset mid-transaction: assert rst_n=0 in RESP between clock edges -> mem_valid=0 and state IDLE immediately; after release a stray mem_rvalid produces no ack.
